wb_reg_bank: RTL and testbench



---
 rtl/wb_reg_bank.sv | 130 +++++++++++++
 tb/tb_wb_reg_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: parametrised Wishbone (pipelined B4) register bank.
//
// Provides REG_COUNT registers of DATA_WIDTH bits. Each bit is read/write, read-only
// (reads the matching status_i bit) or a self-clearing pulse with its own countdown
// of PULSE_CYCLES clocks. Ack follows one cycle after accept and is gated by wb_cycle_i.
//
// Ports:
//   wb_clock_i      system clock
//   wb_reset_i      asynchronous active-high reset
//   wb_addr_i       register index
//   wb_data_i       write data
//   wb_data_o       read data, valid while wb_ack_o is high
//   wb_we_i         1 = write
//   wb_cycle_i      bus cycle active
//   wb_strobe_i     transfer request
//   wb_stall_o      tied to 0, every request is accepted
//   wb_ack_o        transfer complete
//   status_i        sources for read-only bits
//   regs_o          current register state, read-only bits drive 0
//   write_strobe_o  one-cycle pulse per register written
module wb_reg_bank #(
  parameter int unsigned REG_COUNT      = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_ADDR_WIDTH = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] RO_MASK      = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] PULSE_MASK   = '0,
  parameter int unsigned PULSE_CYCLES   = 64
) (
  input  logic                            wb_clock_i,
  input  logic                            wb_reset_i,
  input  logic [REG_ADDR_WIDTH-1:0]       wb_addr_i,
  input  logic [DATA_WIDTH-1:0]           wb_data_i,
  output logic [DATA_WIDTH-1:0]           wb_data_o,
  input  logic                            wb_we_i,
  input  logic                            wb_cycle_i,
  input  logic                            wb_strobe_i,
  output logic                            wb_stall_o,
  output logic                            wb_ack_o,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] status_i,
  output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o,
  output logic [REG_COUNT-1:0]            write_strobe_o
);

  localparam int unsigned NumBits  = REG_COUNT * DATA_WIDTH;
  localparam int unsigned CntWidth = $clog2(PULSE_CYCLES + 1);

  // Read-only wins over pulse where both masks are set.
  localparam logic [NumBits-1:0]  PulseBits = PULSE_MASK & ~RO_MASK;
  localparam logic [NumBits-1:0]  ResetRegs = RESET_VALUES & ~RO_MASK;
  localparam logic [CntWidth-1:0] CntLoad   = CntWidth'(PULSE_CYCLES);
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

  logic                  accept;
  logic [REG_COUNT-1:0]  wr_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [NumBits-1:0]    reg_q, reg_d;
  logic [CntWidth-1:0]   cnt_q [NumBits];
  logic [CntWidth-1:0]   cnt_d [NumBits];
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [REG_COUNT-1:0]  strobe_q;

  assign accept = wb_cycle_i & wb_strobe_i;

  // Out-of-range addresses match no register: no write, no strobe, read data 0.
  always_comb begin
    wr_hit  = '0;
    rd_data = '0;
    for (int n = 0; n < int'(REG_COUNT); n++) begin
      if (32'(wb_addr_i) == 32'(n)) begin
        wr_hit[n] = accept & wb_we_i;
        rd_data   = (reg_q[n*DATA_WIDTH +: DATA_WIDTH] & ~RO_MASK[n*DATA_WIDTH +: DATA_WIDTH]) |
                    (status_i[n*DATA_WIDTH +: DATA_WIDTH] & RO_MASK[n*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  // Per-bit next state. A bus write is applied after the countdown so that a write
  // landing on the expiry edge takes precedence.
  always_comb begin
    reg_d = reg_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NumBits); i++) begin
      if (PulseBits[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CntOne;
          if (cnt_q[i] == CntOne) begin
            reg_d[i] = 1'b0;
          end
        end
        if (wr_hit[i / DATA_WIDTH]) begin
          reg_d[i] = wb_data_i[i % DATA_WIDTH];
          cnt_d[i] = wb_data_i[i % DATA_WIDTH] ? CntLoad : '0;
        end
      end else if (!RO_MASK[i]) begin
        if (wr_hit[i / DATA_WIDTH]) begin
          reg_d[i] = wb_data_i[i % DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      reg_q <= ResetRegs;
      for (int i = 0; i < int'(NumBits); i++) begin
        cnt_q[i] <= (ResetRegs[i] & PulseBits[i]) ? CntLoad : '0;
      end
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      ack_q    <= accept;
      rdata_q  <= (accept && !wb_we_i) ? rd_data : '0;
      strobe_q <= wr_hit;
    end
  end

  // A dropped cycle suppresses the pending ack; the accepted write has already landed.
  assign wb_ack_o       = ack_q & wb_cycle_i;
  assign wb_data_o      = rdata_q;
  assign wb_stall_o     = 1'b0;
  assign regs_o         = reg_q;
  assign write_strobe_o = strobe_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Bench for wb_reg_bank: 3 registers (non-power-of-two, so address 3 is out of range).
// reg0: bits 1:0 pulse (bit 1 resets high), rest RW. reg1: RW. reg2: high nibble RO.
module tb_wb_reg_bank;

  localparam int unsigned RegCount = 3;
  localparam int unsigned Dw       = 8;
  localparam int unsigned Pulse    = 4;
  localparam logic [23:0] ResetVal = 24'hFF5A02;
  localparam logic [23:0] RoMask   = 24'hF00000;
  localparam logic [23:0] PulseMsk = 24'hF00003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        stall;
  logic        ack;
  logic [23:0] status = {8'h3C, 8'hFF, 8'hFF};
  logic [23:0] regs;
  logic [2:0]  wstrobe;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_reg_bank #(
    .REG_COUNT    (RegCount),
    .DATA_WIDTH   (Dw),
    .RESET_VALUES (ResetVal),
    .RO_MASK      (RoMask),
    .PULSE_MASK   (PulseMsk),
    .PULSE_CYCLES (Pulse)
  ) dut (
    .wb_clock_i     (clk),
    .wb_reset_i     (rst),
    .wb_addr_i      (addr),
    .wb_data_i      (wdata),
    .wb_data_o      (rdata),
    .wb_we_i        (we),
    .wb_cycle_i     (cyc),
    .wb_strobe_i    (stb),
    .wb_stall_o     (stall),
    .wb_ack_o       (ack),
    .status_i       (status),
    .regs_o         (regs),
    .write_strobe_o (wstrobe)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic drive(input logic c, input logic s, input logic w, input logic [1:0] a,
                       input logic [7:0] d);
    cyc = c; stb = s; we = w; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 8'h77);
    @(negedge clk);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL reset_ack: got %b want 0", ack);
    end
    vectors++;
    if (rdata !== 8'h00 || wstrobe !== 3'b000 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outs: data=%h strobe=%b stall=%b want 00/000/0", rdata, wstrobe, stall);
    end
    vectors++;
    if (regs !== 24'h0F5A02) begin
      miscompares++; $display("FAIL reset_regs: got %h want 0f5a02", regs);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    // Reset-high pulse bit must stay up for exactly Pulse cycles after release.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if (regs !== ((k < int'(Pulse)) ? 24'h0F5A02 : 24'h0F5A00)) begin
        miscompares++;
        $display("FAIL reset_pulse_k%0d: got %h want %h", k, regs,
                 (k < int'(Pulse)) ? 24'h0F5A02 : 24'h0F5A00);
      end
    end
  endtask

  task automatic test_rw_ro();
    drive(1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++; $display("FAIL rw_ack_early: got %b want 0", ack);
    end
    @(negedge clk);
    vectors++;
    if (ack !== 1'b1 || wstrobe !== 3'b100 || regs[23:16] !== 8'h05) begin
      miscompares++;
      $display("FAIL rw_write2: ack=%b strobe=%b reg2=%h want 1/100/05", ack, wstrobe, regs[23:16]);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    vectors++;
    if (ack !== 1'b0 || wstrobe !== 3'b000) begin
      miscompares++; $display("FAIL rw_one_cycle: ack=%b strobe=%b want 0/000", ack, wstrobe);
    end
    drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    vectors++;
    if (ack !== 1'b1 || rdata !== 8'h35) begin
      miscompares++; $display("FAIL ro_read2: ack=%b data=%h want 1/35", ack, rdata);
    end
    drive(1'b1, 1'b1, 1'b1, 2'd1, 8'hC3);
    @(negedge clk);
    vectors++;
    if (ack !== 1'b1 || wstrobe !== 3'b010 || regs !== 24'h05C300) begin
      miscompares++;
      $display("FAIL rw_write1: ack=%b strobe=%b regs=%h want 1/010/05c300", ack, wstrobe, regs);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_pulse_restart();
    int highs;
    highs = 0;
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h01);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (regs[0]) highs++;
      else break;
      if (c == 1) drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h01);
      else        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    vectors++;
    if (highs != 2 + int'(Pulse)) begin
      miscompares++; $display("FAIL pulse_restart_len: got %0d want %0d", highs, 2 + Pulse);
    end
    // Cancel mid-pulse.
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h01);
    @(negedge clk);
    vectors++;
    if (regs[0] !== 1'b1) begin
      miscompares++; $display("FAIL pulse_set: got %b want 1", regs[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    @(negedge clk);
    vectors++;
    if (regs[0] !== 1'b0) begin
      miscompares++; $display("FAIL pulse_cancel: got %b want 0", regs[0]);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (6) @(negedge clk);
    vectors++;
    if (regs[7:0] !== 8'h00) begin
      miscompares++; $display("FAIL pulse_stays_clear: got %h want 00", regs[7:0]);
    end
  endtask

  task automatic test_write_vs_expiry();
    int highs;
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h01);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h01);
      else        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    vectors++;
    if (regs[0] !== 1'b1) begin
      miscompares++; $display("FAIL expiry_write_wins: got %b want 1", regs[0]);
    end
    highs = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (regs[0]) highs++;
      else break;
    end
    vectors++;
    if (highs != int'(Pulse)) begin
      miscompares++; $display("FAIL expiry_reload_len: got %0d want %0d", highs, Pulse);
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 1'b1, 2'd3, 8'hFF);
    @(negedge clk);
    vectors++;
    if (ack !== 1'b1 || wstrobe !== 3'b000 || regs !== 24'h05C300) begin
      miscompares++;
      $display("FAIL oor_write: ack=%b strobe=%b regs=%h want 1/000/05c300", ack, wstrobe, regs);
    end
    drive(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
    @(negedge clk);
    vectors++;
    if (ack !== 1'b1 || rdata !== 8'h00) begin
      miscompares++; $display("FAIL oor_read: ack=%b data=%h want 1/00", ack, rdata);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic       req_we   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] req_addr [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] req_data [5] = '{8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] req_exp  [5] = '{8'h00, 8'h66, 8'h35, 8'h00, 8'h00};
    exp_t e;
    int acks;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        drive(1'b1, 1'b1, req_we[c], req_addr[c], req_data[c]);
        exp_q.push_back('{rd: !req_we[c], data: req_exp[c]});
      end else begin
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      end
      @(negedge clk);
      if (ack === 1'b1) begin
        acks++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra_ack: got ack with empty queue, want none");
        end else begin
          e = exp_q.pop_front();
          if (e.rd && rdata !== e.data) begin
            miscompares++; $display("FAIL b2b_data%0d: got %h want %h", acks, rdata, e.data);
          end
        end
      end
      if (c >= 5 && exp_q.size() == 0) break;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    vectors++;
    if (acks != 5 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_ack_count: got %0d acks, %0d pending want 5/0", acks, exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_abort();
    drive(1'b1, 1'b1, 1'b1, 2'd1, 8'h11);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    vectors++;
    if (ack !== 1'b0 || regs[15:8] !== 8'h11) begin
      miscompares++; $display("FAIL abort_cyc_drop: ack=%b reg1=%h want 0/11", ack, regs[15:8]);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 8'h22);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    vectors++;
    if (ack !== 1'b0 || regs !== 24'h0F5A02) begin
      miscompares++; $display("FAIL abort_reset: ack=%b regs=%h want 0/0f5a02", ack, regs);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    vectors++;
    if (regs[15:8] !== 8'h5A) begin
      miscompares++; $display("FAIL abort_write_lost: reg1=%h want 5a", regs[15:8]);
    end
  endtask

  initial begin
    test_reset();
    test_rw_ro();
    test_pulse_restart();
    test_write_vs_expiry();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
